// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C init sequencer: table entry layout and FSM encoding.
// Pure declarations, no logic.
package i2c_pkg;

  localparam int ADDR_LSB = 16;
  localparam int SUB_LSB  = 8;
  localparam logic [6:0] DELAY_ADDR = 7'h7F;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH_A,
    ST_FETCH_B,
    ST_ISSUE,
    ST_WAIT_ACCEPT,
    ST_WAIT_DONE,
    ST_GAP,
    ST_DELAY,
    ST_FIN,
    ST_ERR
  } state_t;

  // States in which a go edge may launch a new walk.
  function automatic logic is_rest_state(input state_t s);
    return (s == ST_IDLE) || (s == ST_FIN) || (s == ST_ERR);
  endfunction

endpackage

// File: rtl/i2c_down_counter.sv
// Loadable down counter with zero flag; load has priority, holds at zero.
// Load/decrement take effect one cycle after the request; no backpressure.
module i2c_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && !zero) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/i2c_init_sequencer.sv
// Walks a register-write table after a go edge, feeding each entry to an I2C master.
// Two-cycle fetch per entry; stalls in ISSUE while m_ready is low, timeout covers accept and completion.
module i2c_init_sequencer
  import i2c_pkg::*;
#(
  parameter int NUM_ENTRIES = 16,
  parameter int IDX_W       = 8,
  parameter int TIMEOUT     = 100000,
  parameter int GAP         = 16,
  parameter int DELAY_UNIT  = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  output logic [IDX_W-1:0] tbl_idx,
  input  logic [22:0]      tbl_entry,
  output logic             m_start,
  output logic [6:0]       m_addr,
  output logic [7:0]       m_sub,
  output logic [7:0]       m_data,
  input  logic             m_ready,
  input  logic             m_done,
  output logic             busy,
  output logic             finished,
  output logic             error,
  output logic [IDX_W-1:0] err_idx
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam int DW = 16 + $clog2(DELAY_UNIT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic             go_q;
  logic             go_edge;
  logic             walk_start;
  logic             is_delay;
  logic             last_entry;
  logic             tmo_zero;
  logic             gap_zero;
  logic             dly_zero;
  logic             timeout_hit;
  logic             advance;
  logic [DW-1:0]    delay_load;

  assign go_edge     = go & ~go_q;
  assign walk_start  = go_edge && is_rest_state(state);
  assign is_delay    = (tbl_entry[ADDR_LSB +: 7] == DELAY_ADDR);
  assign last_entry  = (idx == LAST_IDX);
  assign delay_load  = DW'(tbl_entry[15:0]) * DW'(DELAY_UNIT);
  assign tbl_idx     = idx;

  // m_done in the same cycle as expiry counts as success.
  assign timeout_hit = tmo_zero &&
                       ((state == ST_WAIT_ACCEPT) || ((state == ST_WAIT_DONE) && !m_done));

  assign advance = ((state == ST_GAP) && gap_zero) ||
                   ((state == ST_DELAY) && dly_zero) ||
                   ((state == ST_WAIT_DONE) && m_done && (GAP == 0));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE, ST_FIN, ST_ERR: if (go_edge) state_nxt = ST_FETCH_A;
      ST_FETCH_A:              state_nxt = ST_FETCH_B;
      ST_FETCH_B:              state_nxt = is_delay ? ST_DELAY : ST_ISSUE;
      ST_ISSUE:                if (m_ready) state_nxt = ST_WAIT_ACCEPT;
      ST_WAIT_ACCEPT: begin
        if (timeout_hit)   state_nxt = ST_ERR;
        else if (!m_ready) state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (m_done)           state_nxt = ST_GAP;
        else if (timeout_hit) state_nxt = ST_ERR;
      end
      ST_GAP, ST_DELAY:        state_nxt = state;
      default:                 state_nxt = ST_IDLE;
    endcase
    if (advance) state_nxt = last_entry ? ST_FIN : ST_FETCH_A;
  end

  always_comb begin
    m_start  = (state == ST_WAIT_ACCEPT);
    busy     = !is_rest_state(state);
    finished = (state == ST_FIN);
    error    = (state == ST_ERR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      go_q    <= 1'b0;
      idx     <= '0;
      m_addr  <= '0;
      m_sub   <= '0;
      m_data  <= '0;
      err_idx <= '0;
    end else begin
      go_q <= go;
      if (walk_start) begin
        idx <= '0;
      end else if (advance && !last_entry) begin
        idx <= idx + IDX_W'(1);
      end
      if (state == ST_FETCH_B) begin
        m_addr <= tbl_entry[ADDR_LSB +: 7];
        m_sub  <= tbl_entry[SUB_LSB +: 8];
        m_data <= tbl_entry[7:0];
      end
      if (timeout_hit) err_idx <= idx;
    end
  end

  i2c_down_counter #(.W(TW)) u_tmo_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     ((state == ST_ISSUE) && m_ready),
    .load_val (TW'(TIMEOUT)),
    .en       ((state == ST_WAIT_ACCEPT) || (state == ST_WAIT_DONE)),
    .zero     (tmo_zero)
  );

  i2c_down_counter #(.W(GW)) u_gap_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     ((state == ST_WAIT_DONE) && m_done),
    .load_val (GW'(GAP)),
    .en       (state == ST_GAP),
    .zero     (gap_zero)
  );

  i2c_down_counter #(.W(DW)) u_dly_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     ((state == ST_FETCH_B) && is_delay),
    .load_val (delay_load),
    .en       (state == ST_DELAY),
    .zero     (dly_zero)
  );

endmodule

// File: doc/i2c_init_sequencer.md
Name: i2c_init_sequencer

Overview:
- Walks a table of register writes (7-bit device addr, 8-bit sub-address, 8-bit data).
- Issues each entry to I2C_master through its start/ready/done handshake, with no software involvement.
- Sits between a synchronous table ROM and I2C_master, and brings up an attached peripheral after reset.
- Supports in-table delay entries, a per-transaction timeout, and fixed inter-transaction spacing.

Parameters:
- NUM_ENTRIES, 16: number of table entries walked, 1..256.
- IDX_W, 8: width of tbl_idx; must satisfy 2^IDX_W >= NUM_ENTRIES.
- TIMEOUT, 100000: clk cycles allowed from m_start assertion to m_done before error.
- GAP, 16: idle clk cycles inserted after each completed write.
- DELAY_UNIT, 1000: clk cycles per count of a delay entry.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high.
- go  in  1  rising edge (registered) starts a table walk from index 0 when idle or finished/error.
- tbl_idx  out  IDX_W  table read index.
- tbl_entry  in  23  {addr[22:16], sub[15:8], data[7:0]}; valid 1 cycle after tbl_idx changes.
- m_start  out  1  start request to I2C_master.
- m_addr  out  7  device address to master.
- m_sub  out  8  sub-address to master.
- m_data  out  8  data byte to master.
- m_ready  in  1  master idle/accepting.
- m_done  in  1  master transaction complete (level or pulse; sampled high).
- busy  out  1  walk in progress.
- finished  out  1  walk completed; sticky until next go or reset.
- error  out  1  timeout occurred; sticky until next go or reset.
- err_idx  out  IDX_W  index of the entry that timed out.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0. A reset mid-transaction returns to IDLE and drops m_start in the same cycle.
- go is edge-detected, using a registered copy of go cleared by reset. A go edge while busy is ignored.
- FSM states and transitions:
  - IDLE/FIN/ERR + go edge -> FETCH: idx=0, clear finished/error, busy=1.
  - FETCH (2 cycles): drive tbl_idx, then latch tbl_entry into m_addr/m_sub/m_data.
    - Delay entry (addr==7'h7F): load delay counter = {sub,data}*DELAY_UNIT, go to DELAY. m_start is not asserted.
    - Otherwise -> ISSUE.
  - ISSUE: wait for m_ready=1, then assert m_start and start the timeout counter -> WAIT_ACCEPT.
  - WAIT_ACCEPT: hold m_start=1 until m_ready=0, then drop m_start -> WAIT_DONE.
  - WAIT_DONE: on m_done=1 -> GAP, counter=GAP.
  - Timeout: if the timeout counter reaches TIMEOUT in WAIT_ACCEPT or WAIT_DONE, drop m_start, set error=1 and err_idx=idx, clear busy -> ERR.
  - GAP and DELAY: count down to 0, then advance.
  - Advance: if idx==NUM_ENTRIES-1, set finished=1 and busy=0 -> FIN; else idx+1 -> FETCH.
- A delay count of 0 takes exactly 1 cycle in DELAY.
- GAP=0 skips GAP: advance directly from WAIT_DONE.
- m_done is ignored outside WAIT_DONE.
- m_done and timeout in the same cycle: m_done wins.
- m_addr/m_sub/m_data stay stable from FETCH latch until the next FETCH.
- Arithmetic:
  - Timeout counter width is clog2(TIMEOUT+1).
  - Delay counter width is 16+clog2(DELAY_UNIT+1); the product saturates-free by construction.
  - idx does not wrap: FIN is reached before overflow.

Decomposition:
- Shared package i2c_pkg holds:
  - entry field offsets (ADDR_LSB=16, SUB_LSB=8);
  - DELAY_ADDR=7'h7F;
  - the state encoding.
- One natural sub-module: i2c_down_counter (load, enable, zero flag), instantiated for timeout, GAP and DELAY.

Test Plan:
- 3-entry table {55,AA,AA},{68,20,0F},{68,21,00}, model master (ready drops 2 cycles after start, done 50 cycles later) -> three m_start pulses with matching addr/sub/data, GAP of 16 between done and next start, finished=1, busy=0, error=0.
- Entry 1 = {7F,00,03}, DELAY_UNIT=10 -> no m_start for entry 1; 30 (+/-2 overhead) cycles between entry 0 completion and entry 2 start.
- Model never raises m_done on entry 1, TIMEOUT=200 -> error=1, err_idx=1, m_start=0, no further starts; a new go restarts at index 0 and clears error.
- m_ready held low 500 cycles before entry 0 -> m_start stays 0 until m_ready rises, then issues normally (timeout not running while waiting in ISSUE).
- reset asserted during WAIT_DONE -> next cycle all outputs 0, state IDLE; go edge while busy -> ignored, sequence continues unchanged.
